// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding and seven-segment glyph constants.
package bin2bcd_seq_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  // Segment order {g,f,e,d,c,b,a}, active high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bin2bcd_seq_seg7_decode.sv
// Single BCD digit to seven-segment decoder. Codes 10-15 are blanked.
module seg7_decode
  import bin2bcd_seq_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Pure lookup from digit code to glyph.
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock,
// with start/busy/done handshake. Defining BIN2BCD_SEG_EN adds a
// seven-segment output decoded from the registered bcd result.
//
// state   | meaning
// S_IDLE  | waiting for start; bcd holds the last result
// S_SHIFT | add-3 / shift iterations in progress, counter counts down to 0
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
`ifdef BIN2BCD_SEG_EN
  ,
  output logic [7*DIGITS-1:0]   seg
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e                state_q,   state_d;
  logic [WIDTH-1:0]      shreg_q,   shreg_d;
  logic [4*DIGITS-1:0]   scratch_q, scratch_d;
  logic [4*DIGITS-1:0]   bcd_q,     bcd_d;
  logic [CW-1:0]         cnt_q,     cnt_d;
  logic                  busy_q,    busy_d;
  logic                  done_q,    done_d;
  logic [4*DIGITS-1:0]   adj;

  // Next-state logic: accept a request in idle, run one dabble step per cycle
  // in shift, and publish the result on the terminal count.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    adj       = scratch_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d   = bin;
          scratch_d = '0;
          cnt_d     = CW'(WIDTH);
          busy_d    = 1'b1;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Digits are corrected independently; a corrected digit never exceeds 4'hC,
        // so no carry into the neighbour is needed.
        for (int i = 0; i < DIGITS; i++) begin
          if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        {scratch_d, shreg_d} = {adj[4*DIGITS-2:0], shreg_q, 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = scratch_d;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

`ifdef BIN2BCD_SEG_EN
  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    seg7_decode u_dec (
      .digit (bcd_q[4*g +: 4]),
      .seg   (seg[7*g +: 7])
    );
  end
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq at default parameters (WIDTH=8, DIGITS=3).
module tb_bin2bcd_seq;

  logic        clk;
  logic        clr;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
`ifdef BIN2BCD_SEG_EN
  logic [20:0] seg;
`endif

  int n_vec;
  int n_err;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
`ifdef BIN2BCD_SEG_EN
    ,
    .seg   (seg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b;
    logic [11:0] e;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full conversion with exact latency checks; bin is scrambled while busy.
  task automatic run_conv(input logic [7:0] b, input logic [11:0] e);
    bin   = b;
    start = 1'b1;
    tick();
    check("accept_busy_done", {30'd0, busy, done}, 32'b10);
    start = 1'b0;
    bin   = ~b;
    for (int k = 1; k < 8; k++) begin
      tick();
      check("busy_window", {30'd0, busy, done}, 32'b10);
    end
    tick();
    check("done_cycle", {30'd0, busy, done}, 32'b01);
    check("bcd_result", {20'd0, bcd}, {20'd0, e});
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("bcd_held", {20'd0, bcd}, {20'd0, e});
  endtask

  initial begin
    int gap;
    n_vec = 0;
    n_err = 0;

    vecs[0]  = '{8'd0,   12'h000};
    vecs[1]  = '{8'd255, 12'h255};
    vecs[2]  = '{8'd128, 12'h128};
    vecs[3]  = '{8'd1,   12'h001};
    vecs[4]  = '{8'd9,   12'h009};
    vecs[5]  = '{8'd10,  12'h010};
    vecs[6]  = '{8'd59,  12'h059};
    vecs[7]  = '{8'd99,  12'h099};
    vecs[8]  = '{8'd100, 12'h100};
    vecs[9]  = '{8'd199, 12'h199};
    vecs[10] = '{8'd250, 12'h250};
    vecs[11] = '{8'd108, 12'h108};

    // Reset dominates a concurrent start.
    clr   = 1'b1;
    start = 1'b1;
    bin   = 8'd55;
    tick();
    tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_bcd",  {20'd0, bcd}, 32'd0);
`ifdef BIN2BCD_SEG_EN
    check("reset_seg", {11'd0, seg}, {11'd0, 7'h3F, 7'h3F, 7'h3F});
`endif
    clr   = 1'b0;
    start = 1'b0;
    tick();
    check("idle_after_reset", {30'd0, busy, done}, 32'd0);

    for (int i = 0; i < 12; i++) run_conv(vecs[i].b, vecs[i].e);

`ifdef BIN2BCD_SEG_EN
    check("seg_108", {11'd0, seg}, {11'd0, 7'h06, 7'h3F, 7'h7F});
`endif

    // Back-to-back: second start issued in the done cycle; stray start at E3 ignored.
    bin   = 8'd99;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    tick();
    check("b2b_first_done", {31'd0, done}, 32'd1);
    check("b2b_first_bcd", {20'd0, bcd}, 32'h099);
    bin   = 8'd100;
    start = 1'b1;
    tick();
    gap = 1;
    check("b2b_second_accept", {30'd0, busy, done}, 32'b10);
    start = 1'b0;
    tick();
    tick();
    gap += 2;
    bin   = 8'd7;
    start = 1'b1;
    tick();
    gap++;
    start = 1'b0;
    while (!done && gap < 20) begin
      tick();
      gap++;
    end
    check("b2b_gap", gap, 32'd9);
    check("b2b_second_bcd", {20'd0, bcd}, 32'h100);
    tick();
    check("stray_start_ignored", {30'd0, busy, done}, 32'd0);

    // Abort mid-conversion.
    bin   = 8'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_bcd", {20'd0, bcd}, 32'd0);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (done || busy) seen++;
      end
      check("abort_no_done", seen, 32'd0);
    end
    run_conv(8'd42, 12'h042);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
